// File: rtl/dmac_ahb_sram.sv
// -----------------------------------------------------------------------------
// dmac_ahb_sram
//
// AHB-Lite single-port SRAM slave sitting on the DMAC master bus. One address
// phase is decoded per beat; byte, halfword and word accesses are supported.
// A fixed number of wait states (WAIT) stretches every OKAY data phase so the
// master's HREADY stall path gets exercised. Misaligned or oversized accesses
// get the two-cycle ERROR response and never touch memory.
//
// Parameters
//   ADDR_W    word-address bits, depth = 2**ADDR_W 32-bit words
//   WAIT      wait states per OKAY data phase, 0..7
//
// Ports
//   HCLK      clock, rising edge
//   HRESETn   asynchronous active-low reset
//   HSEL      slave select
//   HREADY    bus ready in; address phase accepted only when high
//   HTRANS    transfer type (NONSEQ/SEQ active, IDLE/BUSY not)
//   HSIZE     0 byte, 1 half, 2 word; above 2 is an error
//   HWRITE    1 = write
//   HADDR     byte address; bits above ADDR_W+1 alias
//   HWDATA    write data, little-endian byte lanes
//   HREADYOUT data phase done
//   HRESP     0 OKAY, 1 ERROR
//   HRDATA    read data, full word (master picks lanes)
// -----------------------------------------------------------------------------
module dmac_ahb_sram #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned WAIT   = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITST,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          wcnt_q,  wcnt_d;
  logic [ADDR_W+1:0]   addr_q,  addr_d;
  logic [1:0]          size_q,  size_d;
  logic                write_q, write_d;
  logic                err_q,   err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem [DEPTH];

  logic                accept;
  logic                req_err;
  state_t              accept_state;
  logic                mem_we;
  logic [3:0]          mem_be;
  logic [ADDR_W-1:0]   wr_word;
  logic [ADDR_W-1:0]   rd_word;
  logic [31:0]         rd_raw;
  logic [31:0]         rd_merged;

  // Address bits above the decoded range alias by design.
  logic                unused_haddr;
  assign unused_haddr = ^HADDR[31:ADDR_W+2];

  // Outputs are pure functions of the state, so reset forces them at once.
  always_comb begin
    HREADYOUT = !(state_q inside {ST_WAITST, ST_ERR1});
    HRESP     = state_q inside {ST_ERR1, ST_ERR2};
    HRDATA    = rdata_q;
  end

  // Address-phase decode.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first; a path that leaves one unassigned would infer a latch.
    accept       = 1'b0;
    req_err      = 1'b0;
    accept_state = ST_DATA;

    // HREADYOUT gating keeps accepts out of WAITST/ERR1 even if HREADY glitches.
    accept  = HSEL && HREADY && HTRANS[1] && HREADYOUT;
    req_err = (HSIZE > 3'd2) ||
              ((HSIZE == 3'd1) && HADDR[0]) ||
              ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    if (req_err)               accept_state = ST_ERR1;
    else if (WAIT_CNT != 3'd0) accept_state = ST_WAITST;
    else                       accept_state = ST_DATA;
  end

  // Write port: the beat in DATA commits on the edge that ends it.
  always_comb begin
    mem_we  = (state_q == ST_DATA) && write_q && !err_q;
    wr_word = addr_q[ADDR_W+1:2];
    case (size_q)
      2'd0:    mem_be = 4'b0001 << addr_q[1:0];
      2'd1:    mem_be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: mem_be = 4'b1111;
    endcase
  end

  // Read port with forwarding: a read accepted on the same edge a write to
  // the same word commits must see the new bytes, not the stale array value.
  always_comb begin
    rd_word   = HADDR[ADDR_W+1:2];
    rd_raw    = mem[rd_word];
    rd_merged = rd_raw;
    if (mem_we && (wr_word == rd_word)) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = accept_state;
          wcnt_d  = WAIT_CNT;
        end
      end
      ST_WAITST: begin
        wcnt_d = wcnt_q - 3'd1;
        if (wcnt_q == 3'd1) state_d = ST_DATA;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      addr_d  = HADDR[ADDR_W+1:0];
      size_d  = HSIZE[1:0];
      write_d = HWRITE;
      err_d   = req_err;
      // Read data is captured at the accept edge and held through WAITST.
      if (!HWRITE && !req_err) rdata_d = rd_merged;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // NOTE: the array has no reset; SRAM contents survive HRESETn. A pending
  // write is still dropped because reset clears state_q, which gates mem_we.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be[i]) mem[wr_word][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmac_ahb_sram.sv
// -----------------------------------------------------------------------------
// tb_dmac_ahb_sram
//
// Three slave instances (WAIT=0, 3, 2) share one master-driven bus; HSEL picks
// the target and HREADY is the AND of all HREADYOUTs (idle slaves hold it
// high). Beat tables are run through a pipelined master: the next address
// phase is presented while the previous beat is in its data phase.
// -----------------------------------------------------------------------------
module tb_dmac_ahb_sram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  hsel_v;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hready;

  logic        ro0, ro1, ro2;
  logic        rs0, rs1, rs2;
  logic [31:0] rd0, rd1, rd2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign hready = ro0 & ro1 & ro2;

  dmac_ahb_sram #(.ADDR_W(10), .WAIT(0)) u_w0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[0]), .HREADY(hready),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
    .HWDATA(hwdata), .HREADYOUT(ro0), .HRESP(rs0), .HRDATA(rd0)
  );

  dmac_ahb_sram #(.ADDR_W(10), .WAIT(3)) u_w3 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[1]), .HREADY(hready),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
    .HWDATA(hwdata), .HREADYOUT(ro1), .HRESP(rs1), .HRDATA(rd1)
  );

  dmac_ahb_sram #(.ADDR_W(10), .WAIT(2)) u_w2 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel_v[2]), .HREADY(hready),
    .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HADDR(haddr),
    .HWDATA(hwdata), .HREADYOUT(ro2), .HRESP(rs2), .HRDATA(rd2)
  );

  // One bus beat. idle=1 presents HTRANS=BUSY with HSEL high (must be ignored
  // and answered with a zero-wait OKAY).
  typedef struct {
    string       name;
    bit          idle;
    bit          wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] exp_rdata;
  } beat_t;

  typedef beat_t beat_q_t[$];

  function automatic beat_t mk(input string nm, input bit idle, input bit wr,
                               input logic [2:0] sz, input logic [31:0] a,
                               input logic [31:0] wd, input bit err,
                               input logic [31:0] exp);
    beat_t b;
    b.name = nm; b.idle = idle; b.wr = wr; b.size = sz; b.addr = a;
    b.wdata = wd; b.err = err; b.exp_rdata = exp;
    return b;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic void sample(input int inst, output logic r, output logic s,
                                 output logic [31:0] d);
    case (inst)
      0:       begin r = ro0; s = rs0; d = rd0; end
      1:       begin r = ro1; s = rs1; d = rd1; end
      default: begin r = ro2; s = rs2; d = rd2; end
    endcase
  endfunction

  task automatic drive_idle();
    hsel_v = '0; htrans = 2'b00; hsize = 3'd0; hwrite = 1'b0;
    haddr = '0; hwdata = '0;
  endtask

  task automatic drive_addr(input int inst, input beat_q_t t, input int ai);
    if (ai < t.size()) begin
      hsel_v = 3'(1 << inst);
      htrans = t[ai].idle ? 2'b01 : (t[ai].wr ? 2'b10 : 2'b11);
      hwrite = t[ai].wr;
      hsize  = t[ai].size;
      haddr  = t[ai].addr;
    end else begin
      hsel_v = '0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0; haddr = '0;
    end
  endtask

  // Pipelined master. Called #1 after a rising edge; returns the same way.
  task automatic run_tbl(input int inst, input int wait_n, input beat_q_t t);
    int ai = 0, di = -1, stall = 0, cycles = 0;
    bit done = 0;
    logic r, s;
    logic [31:0] d;
    drive_addr(inst, t, ai);
    hwdata = '0;
    while (!done) begin
      @(negedge clk);
      sample(inst, r, s, d);
      if (di >= 0) begin
        if (t[di].idle) begin
          check({t[di].name, " ready"}, 32'(r), 32'd1);
          check({t[di].name, " resp"},  32'(s), 32'd0);
        end else if (!r) begin
          stall++;
          check({t[di].name, " resp in stall"}, 32'(s), 32'(t[di].err));
          if (!t[di].wr && !t[di].err)
            check({t[di].name, " rdata in stall"}, d, t[di].exp_rdata);
        end else begin
          check({t[di].name, " stall cycles"}, 32'(stall),
                t[di].err ? 32'd1 : 32'(wait_n));
          check({t[di].name, " resp"}, 32'(s), 32'(t[di].err));
          if (!t[di].wr && !t[di].err)
            check({t[di].name, " rdata"}, d, t[di].exp_rdata);
        end
      end
      if (r) begin
        di    = (ai < t.size()) ? ai : -1;
        ai    = (ai < t.size()) ? ai + 1 : ai;
        stall = 0;
      end
      @(posedge clk); #1;
      if (di < 0 && ai >= t.size()) done = 1;
      drive_addr(inst, t, ai);
      hwdata = (di >= 0) ? t[di].wdata : '0;
      cycles++;
      if (cycles > 400) begin
        check("beat table cycle budget", 32'(cycles), 32'd400);
        done = 1;
      end
    end
    drive_idle();
  endtask

  initial begin
    beat_q_t t0, t1, t2, t2b;
    logic r, s;
    logic [31:0] d;

    // WAIT=0: merges, back-to-back hazards, errors, address aliasing.
    t0.push_back(mk("w10",    0, 1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, '0));
    t0.push_back(mk("r10a",   0, 0, 3'd2, 32'h0000_0010, '0, 0, 32'hDEAD_BEEF));
    t0.push_back(mk("wb11",   0, 1, 3'd0, 32'h0000_0011, 32'h0000_AA00, 0, '0));
    t0.push_back(mk("wh12",   0, 1, 3'd1, 32'h0000_0012, 32'h1234_0000, 0, '0));
    t0.push_back(mk("r10b",   0, 0, 3'd2, 32'h0000_0010, '0, 0, 32'h1234_AAEF));
    t0.push_back(mk("busy10", 1, 1, 3'd2, 32'h0000_0010, 32'hFFFF_FFFF, 0, '0));
    t0.push_back(mk("r10c",   0, 0, 3'd2, 32'h0000_0010, '0, 0, 32'h1234_AAEF));
    t0.push_back(mk("w20",    0, 1, 3'd2, 32'h0000_0020, 32'h1111_2222, 0, '0));
    t0.push_back(mk("r20a",   0, 0, 3'd2, 32'h0000_0020, '0, 0, 32'h1111_2222));
    t0.push_back(mk("wb21",   0, 1, 3'd0, 32'h0000_0021, 32'h0000_5500, 0, '0));
    t0.push_back(mk("r20b",   0, 0, 3'd2, 32'h0000_0020, '0, 0, 32'h1111_5522));
    t0.push_back(mk("wb23",   0, 1, 3'd0, 32'h0000_0023, 32'h7700_0000, 0, '0));
    t0.push_back(mk("wh20",   0, 1, 3'd1, 32'h0000_0020, 32'h0000_ABCD, 0, '0));
    t0.push_back(mk("r20c",   0, 0, 3'd2, 32'h0000_0020, '0, 0, 32'h7711_ABCD));
    t0.push_back(mk("w00",    0, 1, 3'd2, 32'h0000_0000, 32'hCAFE_F00D, 0, '0));
    t0.push_back(mk("ew02",   0, 1, 3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 1, '0));
    t0.push_back(mk("eh01",   0, 1, 3'd1, 32'h0000_0001, 32'hFFFF_FFFF, 1, '0));
    t0.push_back(mk("es3",    0, 1, 3'd3, 32'h0000_0000, 32'hFFFF_FFFF, 1, '0));
    t0.push_back(mk("erh03",  0, 0, 3'd1, 32'h0000_0003, '0, 1, '0));
    t0.push_back(mk("r00",    0, 0, 3'd2, 32'h0000_0000, '0, 0, 32'hCAFE_F00D));
    t0.push_back(mk("wwrap",  0, 1, 3'd2, 32'h0000_1000, 32'h0BAD_C0DE, 0, '0));
    t0.push_back(mk("r00w",   0, 0, 3'd2, 32'h0000_0000, '0, 0, 32'h0BAD_C0DE));
    t0.push_back(mk("r1000",  0, 0, 3'd2, 32'h0000_1000, '0, 0, 32'h0BAD_C0DE));
    t0.push_back(mk("wffc",   0, 1, 3'd2, 32'h0000_0FFC, 32'h1357_2468, 0, '0));
    t0.push_back(mk("rtop",   0, 0, 3'd2, 32'hFFFF_FFFC, '0, 0, 32'h1357_2468));

    // WAIT=3: stalls on every OKAY beat, ERROR still two cycles.
    t1.push_back(mk("s_w40",  0, 1, 3'd2, 32'h0000_0040, 32'hA5A5_5A5A, 0, '0));
    t1.push_back(mk("s_r40a", 0, 0, 3'd2, 32'h0000_0040, '0, 0, 32'hA5A5_5A5A));
    t1.push_back(mk("s_wb43", 0, 1, 3'd0, 32'h0000_0043, 32'h3C00_0000, 0, '0));
    t1.push_back(mk("s_r40b", 0, 0, 3'd2, 32'h0000_0040, '0, 0, 32'h3CA5_5A5A));
    t1.push_back(mk("s_ew41", 0, 1, 3'd2, 32'h0000_0041, 32'hFFFF_FFFF, 1, '0));
    t1.push_back(mk("s_r40c", 0, 0, 3'd2, 32'h0000_0040, '0, 0, 32'h3CA5_5A5A));
    t1.push_back(mk("s_wh42", 0, 1, 3'd1, 32'h0000_0042, 32'hBEEF_0000, 0, '0));
    t1.push_back(mk("s_r40d", 0, 0, 3'd2, 32'h0000_0040, '0, 0, 32'hBEEF_5A5A));

    // WAIT=2: seed 0x30 before the reset-mid-beat sequence, verify after.
    t2.push_back(mk("p_w30",  0, 1, 3'd2, 32'h0000_0030, 32'h600D_F00D, 0, '0));
    t2.push_back(mk("p_r30",  0, 0, 3'd2, 32'h0000_0030, '0, 0, 32'h600D_F00D));
    t2b.push_back(mk("p_r30b", 0, 0, 3'd2, 32'h0000_0030, '0, 0, 32'h600D_F00D));
    t2b.push_back(mk("p_w34",  0, 1, 3'd2, 32'h0000_0034, 32'h0102_0304, 0, '0));
    t2b.push_back(mk("p_r34",  0, 0, 3'd2, 32'h0000_0034, '0, 0, 32'h0102_0304));

    // Reset values, checked while reset is held.
    rst_n = 1'b0;
    drive_idle();
    #12;
    sample(0, r, s, d);
    check("rst ready w0", 32'(r), 32'd1); check("rst resp w0", 32'(s), 32'd0); check("rst rdata w0", d, 32'd0);
    sample(1, r, s, d);
    check("rst ready w3", 32'(r), 32'd1); check("rst resp w3", 32'(s), 32'd0); check("rst rdata w3", d, 32'd0);
    sample(2, r, s, d);
    check("rst ready w2", 32'(r), 32'd1); check("rst resp w2", 32'(s), 32'd0); check("rst rdata w2", d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_tbl(0, 0, t0);
    run_tbl(1, 3, t1);
    run_tbl(2, 2, t2);

    // Reset during WAITST of a write to 0x30: outputs drop to reset values
    // immediately and the write never lands.
    hsel_v = 3'b100; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h0000_0030;
    @(posedge clk); #1;
    hsel_v = '0; htrans = 2'b00; hwdata = 32'hBAD0_BAD0;
    @(negedge clk);
    sample(2, r, s, d);
    check("mid-beat stall before reset", 32'(r), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    sample(2, r, s, d);
    check("async rst ready", 32'(r), 32'd1);
    check("async rst resp",  32'(s), 32'd0);
    check("async rst rdata", d, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    hwdata = '0;

    run_tbl(2, 2, t2b);

    // The WAIT=0 instance kept its contents through the reset.
    begin
      beat_q_t t3;
      t3.push_back(mk("r10_after_rst", 0, 0, 3'd2, 32'h0000_0010, '0, 0, 32'h1234_AAEF));
      run_tbl(0, 0, t3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmac_ahb_sram.md
# dmac_ahb_sram

AHB-Lite single-port SRAM slave on the DMAC master bus, the target the DMAC's AHB master reads from and writes to during channel transfers. It decodes one address phase per beat and supports byte, halfword and word accesses. Programmable wait states exercise the DMAC's HREADY_IN stall path. Misaligned or oversized accesses return a two-cycle ERROR response.

## Interface
- ADDR_W, 10, word-address bits; depth = 2^ADDR_W 32-bit words; byte address bits [ADDR_W+1:0] are used, upper bits are ignored.
- WAIT, 0, wait states inserted in every OKAY data phase; legal range 0..7.
- HCLK  in  1  single clock, rising edge.
- HRESETn  in  1  reset, asynchronous and active-low.
- HSEL  in  1  slave select.
- HREADY  in  1  bus ready (hreadyin); an address phase is accepted only when high.
- HTRANS  in  2  transfer type; NONSEQ=2 and SEQ=3 are active, IDLE=0 and BUSY=1 are not.
- HSIZE  in  3  0=byte, 1=half, 2=word; values above 2 are errors.
- HWRITE  in  1  1=write.
- HADDR  in  32  byte address.
- HWDATA  in  32  write data, little-endian byte lanes.
- HREADYOUT  out  1  data phase done.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  32  read data; the full word is returned and the master selects lanes.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1]. On accept, register addr_q, size_q and write_q, and set err_q.
- err_q is set when HSIZE>2, when HSIZE=1 & HADDR[0], or when HSIZE=2 & HADDR[1:0]!=0.
- Non-accepted cycles with HSEL high (IDLE/BUSY) get a zero-wait OKAY response. Cycles with HSEL low are ignored.
- FSM states:
  - IDLE: no data phase pending.
  - WAITST: counting wait states.
  - DATA: final data-phase cycle.
  - ERR1, ERR2: error response.
- FSM transitions:
  - Accept with err → ERR1.
  - Accept with WAIT>0 → WAITST, loading wcnt=WAIT.
  - Accept with WAIT=0 → DATA.
  - WAITST: decrement wcnt; go to DATA when wcnt reaches 1.
  - DATA / ERR2: go to WAITST, DATA or ERR1 if a new beat is accepted in the same cycle, otherwise IDLE.
  - ERR1 → ERR2.
  - Accepts are possible only when HREADYOUT=1, i.e. in IDLE, DATA or ERR2.
- Outputs by state:
  - HREADYOUT=0 in WAITST and ERR1; 1 otherwise.
  - HRESP=1 in ERR1 and ERR2; 0 otherwise.
- Write: performed on the clock edge ending the DATA cycle, using HWDATA sampled in that cycle.
- Byte-enable generation:
  - byte → lane addr_q[1:0];
  - half → lanes {addr_q[1],0} and {addr_q[1],1};
  - word → all four lanes.
- Error beats never write memory.
- Read: memory is read synchronously at the accept edge. HRDATA is valid in DATA and held through WAITST, so it is stable whenever HREADYOUT=1 ends a read.
- Read-after-write hazard: if a read is accepted in the same cycle a write completes to the same word, HRDATA returns the merged new bytes through a forwarding path, never stale data.
- HRDATA holds its last value outside read data phases.
- Memory contents are not reset.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, wcnt=0.
- OKAY latency: data phase is WAIT+1 cycles after the address phase. Back-to-back beats at WAIT=0 run one beat per cycle.
- ERROR: exactly 2 data-phase cycles, independent of WAIT.
- Reset asserted mid data phase: the pending write is dropped and outputs return to reset values immediately (asynchronous).
- HSEL or HTRANS changing during WAITST is ignored, because HREADY is low.
- Address wrap: HADDR bits above ADDR_W+1 alias, so address 4·2^ADDR_W maps to word 0.

## Test plan
- Word write at WAIT=0: write 0x0000_0010 ← 0xDEAD_BEEF, then read 0x10 → HRDATA=0xDEAD_BEEF, HREADYOUT high every cycle, HRESP=0.
- Byte/half merge: write word 0xDEAD_BEEF to 0x10, byte 0xAA to 0x11, then half 0x1234 to 0x12. Read 0x10 → 0x1234_AAEF.
- Wait states at WAIT=3: each beat holds HREADYOUT low for exactly 3 cycles. A master holding HWDATA through the stall writes correctly, and read data is stable on the completing cycle.
- Errors: word to 0x02, half to 0x01, HSIZE=3 → HREADYOUT 0 then 1 with HRESP=1 for both cycles. The memory word at that address is unchanged on readback, and the next beat gets OKAY.
- Hazard: at WAIT=0, write 0x20 ← 0x1111_2222 immediately followed by read 0x20 → 0x1111_2222. Byte write 0x55 to 0x21 followed by read → 0x1111_5522.
- Reset mid-beat at WAIT=2: assert HRESETn low during WAITST of a write to 0x30 → HREADYOUT=1 and HRESP=0 asynchronously. After release, read 0x30 returns its prior value.
